// File: rtl/sdr_read_responder_pkg.sv
// Shared constants for the tile-fetch read responder.
// Describes how one 32-bit fetch word splits into 16-bit SDRAM beats.
package sdr_read_responder_pkg;

  // Bytes carried by one SDRAM controller beat (16-bit data path).
  localparam int SDR_BEAT_BYTES = 2;

  // Bytes in one tile-fetch word (two beats).
  localparam int SDR_WORD_BYTES = 4;

  // Beats needed to assemble one fetch word.
  localparam int SDR_BEATS_PER_WORD = SDR_WORD_BYTES / SDR_BEAT_BYTES;

  // Width of the debug state output of the responder FSM.
  localparam int SDR_STATE_W = 3;

endpackage : sdr_read_responder_pkg

// File: rtl/sdr_read_responder_if.sv
// Bus bundle between the tile-fetch arbiter, the read responder and one
// SDRAM controller channel.
//
// Handshake semantics (all signals sampled on posedge clk):
//   - sdr_req is a one-cycle request strobe qualified by sdr_addr; there is no
//     ready back-pressure, so requests that cannot be held are dropped and
//     flagged on the sticky overflow output.
//   - sdr_rdy is a one-cycle completion strobe; sdr_data is valid while
//     sdr_rdy=1 and holds its value afterwards.
//   - ram_rd is a one-cycle read strobe qualified by ram_addr; the controller
//     answers each strobe with exactly one ram_ack cycle carrying ram_dout,
//     after an unbounded delay.
//   - inv is a one-cycle pulse that drops the cached line.
interface sdr_read_responder_if #(
  parameter int ADDR_W = 25
) ();

  logic [ADDR_W-1:0] sdr_addr;
  logic              sdr_req;
  logic [31:0]       sdr_data;
  logic              sdr_rdy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [15:0]       ram_dout;
  logic              ram_ack;
  logic              inv;
  logic              overflow;

  // Requester + controller side (arbiter, SDRAM controller, or a bench).
  modport master (
    output sdr_addr, sdr_req, ram_dout, ram_ack, inv,
    input  sdr_data, sdr_rdy, ram_addr, ram_rd, overflow
  );

  // Responder side.
  modport slave (
    input  sdr_addr, sdr_req, ram_dout, ram_ack, inv,
    output sdr_data, sdr_rdy, ram_addr, ram_rd, overflow
  );

endinterface : sdr_read_responder_if

// File: rtl/sdr_read_responder.sv
// Tile-fetch read responder: turns each 32-bit read request into two 16-bit
// SDRAM reads (low half first), returns the assembled word, and keeps a
// single-line hit register so back-to-back fetches of the same word skip
// SDRAM. A one-entry pending register absorbs a request arriving while busy.
module sdr_read_responder
  import sdr_read_responder_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter bit HIT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  sdr_read_responder_if.slave    bus,
  output logic [SDR_STATE_W-1:0] dbg_state_o
);

  typedef enum logic [SDR_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RD_LO   = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_RD_HI   = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Clears the byte-in-word bits to form the line address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(SDR_WORD_BYTES - 1));
  // Offset of the high beat inside a line.
  localparam logic [ADDR_W-1:0] BEAT_OFS  = ADDR_W'(SDR_BEAT_BYTES);

  // FSM and registered outputs.
  state_e            state_q;
  logic [ADDR_W-1:0] la_q;
  logic [31:0]       word_q;
  logic              inv_seen_q;
  logic [31:0]       sdr_data_q;
  logic              sdr_rdy_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_rd_q;
  logic              overflow_q;

  // Pending request slot.
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_q;

  // One-line hit register.
  logic              hit_valid_q;
  logic [ADDR_W-1:0] hit_addr_q;
  logic [31:0]       hit_data_q;

  // Decoded per-cycle conditions.
  logic              is_idle;
  logic [ADDR_W-1:0] req_la;
  logic [ADDR_W-1:0] src_la;
  logic              src_valid;
  logic              hit;
  logic              serve_pend;
  logic              req_to_pend;
  logic              pend_store;
  logic              pend_drop;
  logic              store_hit;

  // Request source selection, hit lookup and pending-slot bookkeeping.
  always_comb begin
    is_idle     = (state_q == ST_IDLE);
    req_la      = bus.sdr_addr & LINE_MASK;
    // A held request is older than a fresh strobe, so it is served first.
    src_la      = pend_valid_q ? pend_addr_q : req_la;
    src_valid   = pend_valid_q | bus.sdr_req;
    // inv in the same cycle as the lookup forces a miss.
    hit         = HIT_EN && hit_valid_q && (src_la == hit_addr_q) && !bus.inv;
    serve_pend  = is_idle && pend_valid_q;
    // A new strobe is served directly only when IDLE has nothing held.
    req_to_pend = bus.sdr_req && (!is_idle || pend_valid_q);
    // The slot frees on the edge that serves it, so a strobe on that same
    // edge can take it over.
    pend_store  = req_to_pend && (!pend_valid_q || serve_pend);
    pend_drop   = req_to_pend && !pend_store;
    // Any inv since the fetch started (including this edge) blocks the store.
    store_hit   = HIT_EN && (state_q == ST_DONE) && !inv_seen_q && !bus.inv;
  end

  // Main fetch FSM with registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      la_q       <= '0;
      word_q     <= '0;
      inv_seen_q <= 1'b0;
      sdr_data_q <= '0;
      sdr_rdy_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sdr_rdy_q <= 1'b0;
      ram_rd_q  <= 1'b0;
      if (pend_drop) begin
        overflow_q <= 1'b1;
      end
      if (bus.inv) begin
        inv_seen_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (src_valid) begin
            if (hit) begin
              sdr_rdy_q  <= 1'b1;
              sdr_data_q <= hit_data_q;
            end else begin
              la_q       <= src_la;
              ram_addr_q <= src_la;
              ram_rd_q   <= 1'b1;
              inv_seen_q <= bus.inv;
              state_q    <= ST_RD_LO;
            end
          end
        end
        // ram_rd is high for the whole of this state (one cycle).
        ST_RD_LO: begin
          state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (bus.ram_ack) begin
            word_q[15:0] <= bus.ram_dout;
            ram_addr_q   <= la_q | BEAT_OFS;
            ram_rd_q     <= 1'b1;
            state_q      <= ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (bus.ram_ack) begin
            word_q[31:16] <= bus.ram_dout;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          sdr_rdy_q  <= 1'b1;
          sdr_data_q <= word_q;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Pending slot: filled by a strobe that cannot be served now, emptied
  // when IDLE picks it up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else if (pend_store) begin
      pend_valid_q <= 1'b1;
      pend_addr_q  <= req_la;
    end else if (serve_pend) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Hit register: loaded on DONE, dropped by inv (inv wins a tie).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_valid_q <= 1'b0;
      hit_addr_q  <= '0;
      hit_data_q  <= '0;
    end else begin
      if (bus.inv) begin
        hit_valid_q <= 1'b0;
      end else if (store_hit) begin
        hit_valid_q <= 1'b1;
      end
      if (store_hit) begin
        hit_addr_q <= la_q;
        hit_data_q <= word_q;
      end
    end
  end

  assign bus.sdr_data  = sdr_data_q;
  assign bus.sdr_rdy   = sdr_rdy_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_rd    = ram_rd_q;
  assign bus.overflow  = overflow_q;
  assign dbg_state_o   = state_q;

endmodule : sdr_read_responder

// File: tb/tb_sdr_read_responder.sv
// Bench for sdr_read_responder: one instance with the hit register enabled
// driven through a scoreboard, and one with it disabled for the no-hit case.
module tb_sdr_read_responder;

  localparam int AW = 25;
  localparam logic [AW-1:0] LA_MASK = 25'h1FFFFFC;

  logic clk = 1'b1;
  logic rst;

  sdr_read_responder_if #(.ADDR_W(AW)) bus ();
  sdr_read_responder_if #(.ADDR_W(AW)) nb ();
  logic [2:0] dbg_state;
  logic [2:0] nb_dbg_state;

  sdr_read_responder #(.ADDR_W(AW), .HIT_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  sdr_read_responder #(.ADDR_W(AW), .HIT_EN(1'b0)) dut_nohit (
    .clk         (clk),
    .reset       (rst),
    .bus         (nb.slave),
    .dbg_state_o (nb_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
    if (a == 25'h0010004) return 16'hBEEF;
    if (a == 25'h0010006) return 16'hDEAD;
    return a[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    logic [AW-1:0] la;
    la = a & LA_MASK;
    return {mem_rd(la | 25'h2), mem_rd(la)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0]   exp_q[$];
  int            lat_q[$];
  int            cyc_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            rdy_count = 0;
  int            rd_count  = 0;

  // Output monitor: every completion must match the oldest expected word.
  always @(negedge clk) begin : mon
    int lat;
    int c0;
    if (!rst && bus.sdr_rdy) begin
      rdy_count++;
      if (exp_q.size() == 0) begin
        chk("rdy_unexpected", 32'(bus.sdr_rdy), 32'd0);
      end else begin
        chk("sdr_data", bus.sdr_data, exp_q.pop_front());
        lat = lat_q.pop_front();
        c0  = cyc_q.pop_front();
        if (lat >= 0) chk("latency", 32'(cyc - c0), 32'(lat));
      end
    end
  end

  // SDRAM controller model for the hit-enabled instance.
  int            ack_dly = 1;
  int            ack_cnt = 0;
  logic [AW-1:0] ack_addr;

  always @(negedge clk) begin
    bus.ram_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        bus.ram_ack  = 1'b1;
        bus.ram_dout = mem_rd(ack_addr);
      end
    end
    if (!rst && bus.ram_rd) begin
      rd_count++;
      ack_addr = bus.ram_addr;
      ack_cnt  = ack_dly;
      if (exp_addr_q.size() == 0) chk("ram_rd_unexpected", 32'(bus.ram_rd), 32'd0);
      else chk("ram_addr", 32'(bus.ram_addr), 32'(exp_addr_q.pop_front()));
    end
  end

  // SDRAM controller model for the hit-disabled instance (ack after 1 cycle).
  int            nb_ack_cnt  = 0;
  int            nb_rd_count = 0;
  logic [AW-1:0] nb_ack_addr;

  always @(negedge clk) begin
    nb.ram_ack = 1'b0;
    if (nb_ack_cnt > 0) begin
      nb_ack_cnt--;
      if (nb_ack_cnt == 0) begin
        nb.ram_ack  = 1'b1;
        nb.ram_dout = mem_rd(nb_ack_addr);
      end
    end
    if (!rst && nb.ram_rd) begin
      nb_rd_count++;
      nb_ack_addr = nb.ram_addr;
      nb_ack_cnt  = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [AW-1:0] a, input bit with_inv);
    bus.sdr_addr = a;
    bus.sdr_req  = 1'b1;
    bus.inv      = with_inv;
    @(negedge clk);
    bus.sdr_req  = 1'b0;
    bus.inv      = 1'b0;
  endtask

  // Drive a request and record what it must produce; lat < 0 = not timed.
  task automatic send_req(input logic [AW-1:0] a, input bit miss, input int lat,
                          input bit with_inv);
    logic [AW-1:0] la;
    la = a & LA_MASK;
    exp_q.push_back(word_of(a));
    lat_q.push_back(lat);
    cyc_q.push_back(cyc);
    if (miss) begin
      exp_addr_q.push_back(la);
      exp_addr_q.push_back(la | 25'h2);
    end
    drive_req(a, with_inv);
  endtask

  task automatic pulse_inv();
    bus.inv = 1'b1;
    @(negedge clk);
    bus.inv = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= max_cyc), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic nb_fetch(input logic [AW-1:0] a);
    int n;
    nb.sdr_addr = a;
    nb.sdr_req  = 1'b1;
    @(negedge clk);
    nb.sdr_req  = 1'b0;
    n = 1;
    while (!nb.sdr_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("nohit_latency", 32'(n), 32'd6);
    chk("nohit_data", nb.sdr_data, word_of(a));
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] pool[4];
  logic          m_hit_valid;
  logic [AW-1:0] m_hit_la;

  initial begin : main
    logic [AW-1:0] a;
    logic [AW-1:0] la;
    int            d;
    int            n;
    int            rdy_before;
    int            rd_before;

    pool[0] = 25'h0000040;
    pool[1] = 25'h0000044;
    pool[2] = 25'h0010004;
    pool[3] = 25'h1FFFFFC;

    rst = 1'b1;
    bus.sdr_addr = '0;
    bus.sdr_req  = 1'b0;
    bus.inv      = 1'b0;
    nb.sdr_addr  = '0;
    nb.sdr_req   = 1'b0;
    nb.inv       = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_sdr_rdy",   32'(bus.sdr_rdy),  32'd0);
    chk("rst_sdr_data",  bus.sdr_data,      32'd0);
    chk("rst_ram_rd",    32'(bus.ram_rd),   32'd0);
    chk("rst_ram_addr",  32'(bus.ram_addr), 32'd0);
    chk("rst_overflow",  32'(bus.overflow), 32'd0);
    chk("rst_state",     32'(dbg_state),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic miss: 0xDEADBEEF after 6 cycles, two beats.
    send_req(25'h0010004, 1'b1, 6, 1'b0);
    wait_drain(40);
    chk("miss_rd_count", 32'(rd_count), 32'd2);

    // Same word, different low bits: one-cycle hit, no SDRAM traffic.
    send_req(25'h0010006, 1'b0, 1, 1'b0);
    wait_drain(20);
    chk("hit_rd_count", 32'(rd_count), 32'd2);

    // inv drops the line: refetch from SDRAM.
    pulse_inv();
    send_req(25'h0010004, 1'b1, 6, 1'b0);
    wait_drain(40);
    chk("inv_rd_count", 32'(rd_count), 32'd4);

    // inv in the same cycle as a hit lookup forces a miss.
    send_req(25'h0010004, 1'b1, 6, 1'b1);
    wait_drain(40);
    pulse_inv();

    // inv during a fetch: word returned but not kept.
    send_req(25'h0000080, 1'b1, 6, 1'b0);
    pulse_inv();
    wait_drain(40);
    send_req(25'h0000080, 1'b1, 6, 1'b0);
    wait_drain(40);
    send_req(25'h0000082, 1'b0, 1, 1'b0);
    wait_drain(20);

    // A, B two cycles later, C one cycle after B, slow acks: A then B, C dropped.
    chk("ovf_before", 32'(bus.overflow), 32'd0);
    ack_dly = 5;
    send_req(25'h0000100, 1'b1, 14, 1'b0);
    @(negedge clk);
    send_req(25'h0000200, 1'b1, -1, 1'b0);
    drive_req(25'h0000300, 1'b0);
    wait_drain(100);
    chk("ovf_after_drop", 32'(bus.overflow), 32'd1);

    // Randomised sequential traffic against a one-line hit model.
    pulse_inv();
    m_hit_valid = 1'b0;
    m_hit_la    = '0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_inv();
        m_hit_valid = 1'b0;
      end
      a  = pool[$urandom_range(0, 3)] | 25'($urandom_range(0, 3));
      la = a & LA_MASK;
      d  = $urandom_range(1, 3);
      ack_dly = d;
      if (m_hit_valid && m_hit_la == la) begin
        send_req(a, 1'b0, 1, 1'b0);
      end else begin
        send_req(a, 1'b1, 2 * d + 4, 1'b0);
        m_hit_valid = 1'b1;
        m_hit_la    = la;
      end
      wait_drain(60);
    end

    // Reset during WAIT_HI: the late ack must be ignored.
    ack_dly = 4;
    exp_addr_q.push_back(25'h0000400);
    exp_addr_q.push_back(25'h0000402);
    drive_req(25'h0000400, 1'b0);
    n = 0;
    while (dbg_state != 3'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait_hi", 32'(dbg_state), 32'd4);
    rdy_before = rdy_count;
    rd_before  = rd_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_late_ack_no_rdy", 32'(rdy_count), 32'(rdy_before));
    chk("rst_late_ack_no_rd",  32'(rd_count),  32'(rd_before));
    chk("rst_mid_state",       32'(dbg_state), 32'd0);
    chk("rst_mid_overflow",    32'(bus.overflow), 32'd0);
    ack_dly = 1;
    send_req(25'h0000400, 1'b1, 6, 1'b0);
    wait_drain(40);

    // Hit register disabled: same address twice, both go to SDRAM.
    nb_fetch(25'h0010004);
    nb_fetch(25'h0010004);
    chk("nohit_rd_count", 32'(nb_rd_count), 32'd4);

    chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sdr_read_responder
